// File: rtl/tabl_sweep_capture_if.sv
// Bundles the sweep request/status and the cell stimulus/response signals.
// The slave modport is the capture block; the master modport is its controller/cell side.
interface tabl_sweep_capture_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [N_IN-1:0]        x_out;
    logic                   y_in;
    logic [(1<<N_IN)-1:0]   table_out;
    logic [N_IN:0]          ones_cnt;
    logic                   mismatch;
    logic [N_IN-1:0]        bad_idx;

    modport master (
        output start, y_in,
        input  busy, done, x_out, table_out, ones_cnt, mismatch, bad_idx
    );

    modport slave (
        input  start, y_in,
        output busy, done, x_out, table_out, ones_cnt, mismatch, bad_idx
    );
endinterface

// File: rtl/tabl_sweep_capture.sv
// Sweeps the inputs of an external truth-table cell, samples its output and rebuilds the table.
// Optional compare against EXPECT is enabled by defining the macro TABL_CHECK_EN.
module tabl_sweep_capture #(
    parameter int                 N_IN   = 4,
    parameter int                 SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 16'h0AC5
) (
    input  logic                 clk,
    input  logic                 rst,
    tabl_sweep_capture_if.slave  bus
);
    localparam int TBL_W = 1 << N_IN;
    localparam int WC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WC_W-1:0] WC_INIT = WC_W'(SETTLE - 1);

    if (SETTLE < 1 || $bits(EXPECT) != TBL_W) begin : g_bad_param
        $error("tabl_sweep_capture: SETTLE must be >= 1 and EXPECT must be 2^N_IN bits");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [WC_W-1:0]    wc_q, wc_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic [N_IN:0]      ones_q, ones_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            wc_q    <= '0;
            tbl_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            wc_q    <= wc_d;
            tbl_q   <= tbl_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_d     = x_q;
        wc_d    = wc_q;
        tbl_d   = tbl_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    wc_d    = WC_INIT;
                    tbl_d   = '0;
                    ones_d  = '0;
                end
            end
            WAIT: begin
                if (wc_q != '0) begin
                    wc_d = wc_q - 1'b1;
                end else begin
                    // Sample point: the current code has been held SETTLE cycles.
                    tbl_d[x_q] = bus.y_in;
                    ones_d     = ones_q + {{N_IN{1'b0}}, bus.y_in};
                    if (x_q == {N_IN{1'b1}}) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = '0;
                    end else begin
                        x_d  = x_q + 1'b1;
                        wc_d = WC_INIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.x_out     = x_q;
    assign bus.table_out = tbl_q;
    assign bus.ones_cnt  = ones_q;

`ifdef TABL_CHECK_EN
    logic            mm_q;
    logic [N_IN-1:0] bad_q;

    // Only the first disagreement is recorded; the flag stays set until the next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q  <= 1'b0;
            bad_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            mm_q  <= 1'b0;
            bad_q <= '0;
        end else if (state_q == WAIT && wc_q == '0 && !mm_q && (bus.y_in != EXPECT[x_q])) begin
            mm_q  <= 1'b1;
            bad_q <= x_q;
        end
    end

    assign bus.mismatch = mm_q;
    assign bus.bad_idx  = bad_q;
`else
    assign bus.mismatch = 1'b0;
    assign bus.bad_idx  = '0;
`endif

endmodule

// File: tb/tb_tabl_sweep_capture.sv
// Bench for tabl_sweep_capture: two instances (SETTLE=1 and SETTLE=3) share stimulus and are
// checked every cycle against a timeline model, plus literal expectations per scenario.
module tb_tabl_sweep_capture;
`ifdef TABL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ones_mode = 1'b0;
    logic checking = 1'b0;
    logic [15:0] ref_tbl = 16'h0AC5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tabl_sweep_capture_if #(.N_IN(4)) if0 ();
    tabl_sweep_capture_if #(.N_IN(4)) if1 ();

    tabl_sweep_capture #(.N_IN(4), .SETTLE(1), .EXPECT(16'h0AC5)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    tabl_sweep_capture #(.N_IN(4), .SETTLE(3), .EXPECT(16'h0AC5)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // The external cell: either the reference table or a constant 1.
    assign if0.start = start;
    assign if1.start = start;
    assign if0.y_in  = ones_mode ? 1'b1 : ref_tbl[if0.x_out];
    assign if1.y_in  = ones_mode ? 1'b1 : ref_tbl[if1.x_out];

    logic [1:0]  dut_busy, dut_done, dut_mm;
    logic [3:0]  dut_x[2];
    logic [3:0]  dut_bad[2];
    logic [15:0] dut_tbl[2];
    logic [4:0]  dut_ones[2];

    assign dut_busy[0] = if0.busy;      assign dut_busy[1] = if1.busy;
    assign dut_done[0] = if0.done;      assign dut_done[1] = if1.done;
    assign dut_mm[0]   = if0.mismatch;  assign dut_mm[1]   = if1.mismatch;
    assign dut_x[0]    = if0.x_out;     assign dut_x[1]    = if1.x_out;
    assign dut_bad[0]  = if0.bad_idx;   assign dut_bad[1]  = if1.bad_idx;
    assign dut_tbl[0]  = if0.table_out; assign dut_tbl[1]  = if1.table_out;
    assign dut_ones[0] = if0.ones_cnt;  assign dut_ones[1] = if1.ones_cnt;

    // Model: mt = cycles since the accepted start (0 idle, 1..16*S busy, 16*S+1 done pulse).
    int          mt[2];
    logic [15:0] mtbl[2];
    logic        mmm[2];
    logic [3:0]  mbad[2];

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step(input int i);
        int s;
        int code;
        logic y;
        s = settle_of(i);
        if (rst) begin
            mt[i] = 0; mtbl[i] = '0; mmm[i] = 1'b0; mbad[i] = '0;
        end else if (mt[i] == 0) begin
            if (start) begin
                mt[i] = 1; mtbl[i] = '0; mmm[i] = 1'b0; mbad[i] = '0;
            end
        end else if (mt[i] <= 16 * s) begin
            code = (mt[i] - 1) / s;
            if (mt[i] % s == 0) begin
                y = ones_mode ? 1'b1 : ref_tbl[code];
                mtbl[i][code] = y;
                if (CHECK_EN && !mmm[i] && (y != ref_tbl[code])) begin
                    mmm[i]  = 1'b1;
                    mbad[i] = 4'(code);
                end
            end
            mt[i] = mt[i] + 1;
        end else begin
            mt[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mt[i] = 0; mtbl[i] = '0; mmm[i] = 1'b0; mbad[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int i = 0; i < 2; i++) begin
                    int  s;
                    logic eb;
                    s  = settle_of(i);
                    eb = (mt[i] >= 1) && (mt[i] <= 16 * s);
                    check("busy", i, 32'(dut_busy[i]), 32'(eb));
                    check("done", i, 32'(dut_done[i]), 32'(mt[i] == 16 * s + 1));
                    check("x_out", i, 32'(dut_x[i]), eb ? 32'((mt[i] - 1) / s) : 32'd0);
                    check("table_out", i, 32'(dut_tbl[i]), 32'(mtbl[i]));
                    check("ones_cnt", i, 32'(dut_ones[i]), 32'($countones(mtbl[i])));
                    check("mismatch", i, 32'(dut_mm[i]), 32'(mmm[i]));
                    check("bad_idx", i, 32'(dut_bad[i]), 32'(mbad[i]));
                end
            end
        end
    end

    // Called at a negedge: raise start for one cycle and time both done pulses.
    task automatic pulse_and_time(output int n0, output int n1);
        n0 = -1;
        n1 = -1;
        start = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (dut_done[0] && n0 < 0) n0 = n;
            if (dut_done[1] && n1 < 0) n1 = n;
            if (n0 >= 0 && n1 >= 0) break;
        end
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((dut_busy != 2'b00 || dut_done != 2'b00) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("quiet_timeout", 0, 32'(k < 200), 32'd1);
    endtask

    initial begin
        int n0, n1, dones, k;

        // Reset
        @(posedge clk);
        @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", i, 32'(dut_busy[i]), 32'd0);
            check("rst_table", i, 32'(dut_tbl[i]), 32'd0);
            check("rst_x", i, 32'(dut_x[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Reference cell, single start pulse
        ones_mode = 1'b0;
        pulse_and_time(n0, n1);
        check("t1_done_cycle", 0, 32'(n0), 32'd17);
        check("t1_done_cycle", 1, 32'(n1), 32'd49);
        check("t1_table", 0, 32'(dut_tbl[0]), 32'h0AC5);
        check("t1_table", 1, 32'(dut_tbl[1]), 32'h0AC5);
        check("t1_ones", 0, 32'(dut_ones[0]), 32'd6);
        check("t1_ones", 1, 32'(dut_ones[1]), 32'd6);
        check("t1_mismatch", 0, 32'(dut_mm[0]), 32'd0);
        check("t1_model_table", 0, 32'(mtbl[0]), 32'h0AC5);
        wait_quiet();

        // Cell output tied to 1
        ones_mode = 1'b1;
        pulse_and_time(n0, n1);
        check("t2_done_cycle", 0, 32'(n0), 32'd17);
        check("t2_table", 0, 32'(dut_tbl[0]), 32'hFFFF);
        check("t2_table", 1, 32'(dut_tbl[1]), 32'hFFFF);
        check("t2_ones", 0, 32'(dut_ones[0]), 32'd16);
        check("t2_mismatch", 0, 32'(dut_mm[0]), CHECK_EN ? 32'd1 : 32'd0);
        check("t2_bad_idx", 0, 32'(dut_bad[0]), CHECK_EN ? 32'd1 : 32'd0);
        check("t2_bad_idx", 1, 32'(dut_bad[1]), CHECK_EN ? 32'd1 : 32'd0);
        check("t2_model_bad", 0, 32'(mbad[0]), CHECK_EN ? 32'd1 : 32'd0);
        wait_quiet();

        // start held high for 60 cycles: back-to-back sweeps with one idle cycle between
        ones_mode = 1'b0;
        start = 1'b1;
        dones = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (dut_done[0]) dones++;
            if (n == 17) check("t4_done_17", 0, 32'(dut_done[0]), 32'd1);
            if (n == 18) check("t4_idle_gap", 0, 32'(dut_busy[0]), 32'd0);
            if (n == 19) check("t4_restart", 0, 32'(dut_busy[0]), 32'd1);
        end
        start = 1'b0;
        check("t4_done_count", 0, 32'(dones), 32'd3);
        wait_quiet();
        check("t4_table", 0, 32'(dut_tbl[0]), 32'h0AC5);

        // Reset in the middle of a sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(dut_busy[0] && dut_x[0] == 4'd7) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_x7", 0, 32'(k < 40), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t5_busy", i, 32'(dut_busy[i]), 32'd0);
            check("t5_done", i, 32'(dut_done[i]), 32'd0);
            check("t5_x", i, 32'(dut_x[i]), 32'd0);
            check("t5_table", i, 32'(dut_tbl[i]), 32'd0);
            check("t5_ones", i, 32'(dut_ones[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        pulse_and_time(n0, n1);
        check("t5_done_cycle", 0, 32'(n0), 32'd17);
        check("t5_table", 0, 32'(dut_tbl[0]), 32'h0AC5);
        check("t5_table", 1, 32'(dut_tbl[1]), 32'h0AC5);
        wait_quiet();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
